// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//   Inter-stage pipeline register with a valid/ready handshake and a 2-entry
//   skid buffer. It carries one packed stage bundle at full throughput under
//   backpressure. Main register M drives the output; skid register S catches
//   the beat that arrives while M is stalled. A flush clears the stage but can
//   keep selected M bits, such as a PC field needed for exception reporting.
//   A saturating counter records stalled output cycles for performance debug.
//
// Parameters
//   WIDTH      payload width in bits
//   KEEP_MASK  1 = main-register bit kept on flush, 0 = bit cleared
//   RESET_VAL  main-register value after reset
//   CNT_W      stall counter width
//
// Ports
//   i_clk        rising-edge clock
//   i_reset      synchronous active-high reset; takes priority over flush
//   i_flush      drop every held entry
//   i_in_valid   upstream presents i_in_data
//   o_in_ready   block can accept a beat this cycle
//   i_in_data    upstream payload
//   o_out_valid  o_out_data is valid
//   i_out_ready  downstream consumes a beat this cycle
//   o_out_data   payload, always the main register
//   o_occupancy  number of entries held: 0, 1 or 2
//   o_stall_cnt  saturating count of cycles with o_out_valid & ~i_out_ready
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int unsigned          WIDTH     = 32,
    parameter logic [WIDTH-1:0]     KEEP_MASK = '0,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [1:0]       o_occupancy,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_skid_d;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_cnt_d;

    logic w_in_ready;
    logic w_out_valid;
    logic w_accept;
    logic w_emit;

    // Handshake qualifiers. in_ready is gated by reset so nothing is accepted
    // while the block is being cleared.
    always_comb begin
        w_in_ready  = (r_state != StFull) & ~i_reset;
        w_out_valid = (r_state != StEmpty);
        w_accept    = i_in_valid & w_in_ready;
        w_emit      = w_out_valid & i_out_ready;
    end

    // Next-state and storage update.
    always_comb begin
        w_state_d = r_state;
        w_main_d  = r_main;
        w_skid_d  = r_skid;

        unique case (r_state)
            StEmpty: begin
                if (w_accept) begin
                    w_main_d  = i_in_data;
                    w_state_d = StOne;
                end
            end
            StOne: begin
                if (w_accept && w_emit) begin
                    w_main_d = i_in_data;
                end else if (w_accept) begin
                    // M is stalled, so the new beat parks in the skid register.
                    w_skid_d  = i_in_data;
                    w_state_d = StFull;
                end else if (w_emit) begin
                    w_state_d = StEmpty;
                end
            end
            StFull: begin
                // in_ready is low here, so only a drain can happen.
                if (w_emit) begin
                    w_main_d  = r_skid;
                    w_state_d = StOne;
                end
            end
            default: begin
                w_state_d = StEmpty;
            end
        endcase

        // Flush overrides every handshake decided above in this cycle.
        if (i_flush) begin
            w_state_d = StEmpty;
            w_main_d  = r_main & KEEP_MASK;
            w_skid_d  = '0;
        end
    end

    // The stall counter looks at the pre-flush handshake and survives a flush.
    always_comb begin
        w_stall_cnt_d = r_stall_cnt;
        if (w_out_valid && !i_out_ready && (r_stall_cnt != CntMax)) begin
            w_stall_cnt_d = r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StEmpty;
            r_main      <= RESET_VAL;
            r_skid      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_d;
            r_main      <= w_main_d;
            r_skid      <= w_skid_d;
            r_stall_cnt <= w_stall_cnt_d;
        end
    end

    always_comb begin
        o_in_ready  = w_in_ready;
        o_out_valid = w_out_valid;
        o_out_data  = r_main;
        o_stall_cnt = r_stall_cnt;
        unique case (r_state)
            StEmpty: o_occupancy = 2'd0;
            StOne:   o_occupancy = 2'd1;
            StFull:  o_occupancy = 2'd2;
            default: o_occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//   Directed bench for pipe_stage_skid, built with KEEP_MASK=0xFFFF0000,
//   RESET_VAL=0xDEADBEEF and CNT_W=4. Inputs change 1 time unit after a
//   rising edge, and outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int unsigned      WIDTH = 32;
    localparam int unsigned      CNT_W = 4;
    localparam logic [WIDTH-1:0] KEEP  = 32'hFFFF_0000;
    localparam logic [WIDTH-1:0] RVAL  = 32'hDEAD_BEEF;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    int n_tests;
    int n_fail;

    pipe_stage_skid #(
        .WIDTH     (WIDTH),
        .KEEP_MASK (KEEP),
        .RESET_VAL (RVAL),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_occupancy (occupancy),
        .o_stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset.
        tick();
        chk("rst_in_ready_low", 32'(in_ready), 0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_out_data", out_data, RVAL);
        chk("rst_stall", 32'(stall_cnt), 0);

        // Test 1: stream 0x11..0x18 with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h11 + 32'(i);
            chk("t1_in_ready", 32'(in_ready), 1);
            tick();
            chk("t1_out_valid", 32'(out_valid), 1);
            chk("t1_out_data", out_data, 32'h11 + 32'(i));
            chk("t1_occ", 32'(occupancy), 1);
        end
        in_valid = 1'b0;
        tick();
        chk("t1_drained_occ", 32'(occupancy), 0);
        chk("t1_drained_valid", 32'(out_valid), 0);
        chk("t1_stall", 32'(stall_cnt), 0);

        // Test 2: two beats pile up behind a stalled output, then drain.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        chk("t2_occ1", 32'(occupancy), 1);
        chk("t2_data_a", out_data, 32'hA);
        in_data = 32'hB;
        chk("t2_ready_one", 32'(in_ready), 1);
        tick();
        chk("t2_occ2", 32'(occupancy), 2);
        chk("t2_ready_full", 32'(in_ready), 0);
        chk("t2_hold_a", out_data, 32'hA);
        chk("t2_stall1", 32'(stall_cnt), 1);
        in_valid = 1'b0;
        tick();
        chk("t2_stall2", 32'(stall_cnt), 2);
        chk("t2_still_a", out_data, 32'hA);
        chk("t2_still_full", 32'(occupancy), 2);
        out_ready = 1'b1;
        tick();
        chk("t2_occ_after_a", 32'(occupancy), 1);
        chk("t2_data_b", out_data, 32'hB);
        tick();
        chk("t2_occ_empty", 32'(occupancy), 0);
        chk("t2_stall_kept", 32'(stall_cnt), 2);

        // Test 3: flush keeps only the masked upper half of M.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1234_ABCD;
        tick();
        chk("t3_loaded", out_data, 32'h1234_ABCD);
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_valid", 32'(out_valid), 0);
        chk("t3_occ", 32'(occupancy), 0);
        chk("t3_data", out_data, 32'h1234_0000);
        chk("t3_stall_preflush", 32'(stall_cnt), 3);

        // Test 4: flush while FULL with in_valid high drops everything.
        in_valid = 1'b1;
        in_data  = 32'h21;
        tick();
        in_data = 32'h22;
        tick();
        chk("t4_full", 32'(occupancy), 2);
        in_data = 32'h23;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t4_occ", 32'(occupancy), 0);
        chk("t4_valid", 32'(out_valid), 0);
        chk("t4_ready", 32'(in_ready), 1);
        chk("t4_data", out_data, 32'h0);
        chk("t4_stall", 32'(stall_cnt), 5);

        // Flush in ONE discards a same-cycle accept and the emit.
        in_valid = 1'b1;
        in_data  = 32'h00AB_0031;
        tick();
        chk("t4b_loaded", out_data, 32'h00AB_0031);
        in_data   = 32'h32;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t4b_occ", 32'(occupancy), 0);
        chk("t4b_data", out_data, 32'h00AB_0000);
        chk("t4b_stall", 32'(stall_cnt), 5);

        // Test 5: stall counter saturates at 15 and survives a flush.
        in_valid = 1'b1;
        in_data  = 32'h55;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        chk("t5_sat", 32'(stall_cnt), 15);
        chk("t5_held", out_data, 32'h55);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flush_keeps", 32'(stall_cnt), 15);
        chk("t5_flush_occ", 32'(occupancy), 0);

        // Test 6: reset while FULL with in_valid and flush also high.
        in_valid = 1'b1;
        in_data  = 32'h61;
        tick();
        in_data = 32'h62;
        tick();
        chk("t6_full", 32'(occupancy), 2);
        reset   = 1'b1;
        flush   = 1'b1;
        in_data = 32'h63;
        #1;
        chk("t6_ready_in_rst", 32'(in_ready), 0);
        tick();
        chk("t6_ready_in_rst2", 32'(in_ready), 0);
        chk("t6_occ_rst", 32'(occupancy), 0);
        chk("t6_valid_rst", 32'(out_valid), 0);
        chk("t6_data_rst", out_data, RVAL);
        chk("t6_stall_rst", 32'(stall_cnt), 0);
        tick();
        chk("t6_occ_rst2", 32'(occupancy), 0);
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t6_ready_after", 32'(in_ready), 1);
        chk("t6_valid_after", 32'(out_valid), 0);
        chk("t6_data_after", out_data, RVAL);
        tick();
        chk("t6_no_spurious", 32'(out_valid), 0);
        chk("t6_occ_after", 32'(occupancy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
